// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM port status and the RAM arbiter state encoding.
package cpu_types_pkg;

  // Status reported by the RAM model each cycle.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // RAM arbiter states: waiting for a winner, first word, second (locked) word.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WORD1 = 2'd1,
    WORD2 = 2'd2
  } arb_state_t;

  localparam int WORD_W = 32;

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector. The search starts one past
// last_owner and wraps, so the previous owner has the lowest priority.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_owner,
  output logic [NREQ-1:0] onehot,
  output logic [IDW-1:0]  idx,
  output logic            found
);

  logic [IDW-1:0] cand;

  // Walk the rotated request vector and keep the first hit.
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDW'((int'(last_owner) + i) % NREQ);
      if (!found && req[cand]) begin
        found        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single RAM port among NREQ cache-side requesters.
// One owner at a time; the grant is held for a second word when lock is set.
// Handshake: a requester holds req (and its addr/wdata/wen/lock) until its
// rwait bit drops; rwait low for one cycle means that word completed, and
// rdata is valid in that cycle only. Dropping req before completion aborts.
// Optional feature: define MEMARB_DPRIO_EN to favour data requesters (DMASK)
// with a starvation guard for instruction requesters.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int              NREQ       = 4,
  parameter logic [NREQ-1:0] DMASK      = 4'b1100,
  parameter int              STARVE_MAX = 8,
  localparam int             IDW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        wen,
  input  logic [NREQ-1:0]        lock,
  input  logic [NREQ*WORD_W-1:0] addr,
  input  logic [NREQ*WORD_W-1:0] wdata,
  output logic [WORD_W-1:0]      rdata,
  output logic [NREQ-1:0]        rwait,
  output logic                   grant_valid,
  output logic [IDW-1:0]         grant_id,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [WORD_W-1:0]      ramaddr,
  output logic [WORD_W-1:0]      ramstore,
  input  logic [WORD_W-1:0]      ramload,
  input  ramstate_t              ramstate,
  output arb_state_t             dbg_state
);

  arb_state_t     state, state_n;
  logic [IDW-1:0] owner, owner_n;
  logic [IDW-1:0] last_owner, last_n;
  logic [IDW-1:0] win_idx;
  logic           win_found;

  logic [WORD_W-1:0] own_addr, own_wdata;
  logic              own_req, own_wen, own_lock;

  assign dbg_state = state;
  assign rdata     = ramload;

`ifdef MEMARB_DPRIO_EN
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0]   starve_cnt, starve_n;
  logic [NREQ-1:0] dreq, ireq;
  logic [NREQ-1:0] unused_oh_d, unused_oh_i;
  logic [IDW-1:0]  d_idx, i_idx;
  logic            d_found, i_found, win_is_data;

  assign dreq = req & DMASK;
  assign ireq = req & ~DMASK;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick_d (
    .req        (dreq),
    .last_owner (last_owner),
    .onehot     (unused_oh_d),
    .idx        (d_idx),
    .found      (d_found)
  );

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick_i (
    .req        (ireq),
    .last_owner (last_owner),
    .onehot     (unused_oh_i),
    .idx        (i_idx),
    .found      (i_found)
  );

  // Data class wins unless it is empty or instruction fetch has starved.
  always_comb begin
    win_is_data = d_found;
    if (i_found && (starve_cnt == SW'(STARVE_MAX) || !d_found)) begin
      win_is_data = 1'b0;
    end
    win_idx   = win_is_data ? d_idx : i_idx;
    win_found = d_found | i_found;
  end

  // Count data grants made over a pending instruction request; clear on an
  // instruction grant; saturate at STARVE_MAX.
  always_comb begin
    starve_n = starve_cnt;
    if (state == IDLE && win_found) begin
      if (!win_is_data) begin
        starve_n = '0;
      end else if (i_found && starve_cnt != SW'(STARVE_MAX)) begin
        starve_n = starve_cnt + 1'b1;
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_n;
    end
  end
`else
  logic [NREQ-1:0] unused_oh;
  logic            unused_cfg;

  assign unused_cfg = ^{DMASK, 32'(STARVE_MAX)};

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req        (req),
    .last_owner (last_owner),
    .onehot     (unused_oh),
    .idx        (win_idx),
    .found      (win_found)
  );
`endif

  // Select the current owner's request fields.
  always_comb begin
    own_addr  = '0;
    own_wdata = '0;
    own_req   = 1'b0;
    own_wen   = 1'b0;
    own_lock  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == IDW'(i)) begin
        own_addr  = addr[i*WORD_W +: WORD_W];
        own_wdata = wdata[i*WORD_W +: WORD_W];
        own_req   = req[i];
        own_wen   = wen[i];
        own_lock  = lock[i];
      end
    end
  end

  // Next state: arbitrate in IDLE, advance on ACCESS, abort on a dropped req.
  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n  = last_owner;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_n = WORD1;
          owner_n = win_idx;
          last_n  = win_idx;
        end
      end
      WORD1: begin
        if (!own_req) begin
          state_n = IDLE;
        end else if (ramstate == ACCESS) begin
          state_n = own_lock ? WORD2 : IDLE;
        end
      end
      WORD2: begin
        if (!own_req || ramstate == ACCESS) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // RAM strobes and per-requester waits; only a live owner sees a wait drop.
  always_comb begin
    rwait    = '1;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (state != IDLE) begin
      ramaddr  = own_addr;
      ramstore = own_wdata;
      if (own_req) begin
        ramREN = !own_wen;
        ramWEN = own_wen;
        if (ramstate == ACCESS) begin
          rwait[owner] = 1'b0;
        end
      end
    end
  end

  // State, ownership and registered grant outputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      owner       <= '0;
      last_owner  <= IDW'(NREQ - 1);
      grant_valid <= 1'b0;
      grant_id    <= '0;
    end else begin
      state       <= state_n;
      owner       <= owner_n;
      last_owner  <= last_n;
      grant_valid <= (state_n != IDLE);
      grant_id    <= owner_n;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed, table-driven bench for ram_arbiter (4 requesters).
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  localparam logic [31:0] A0 = 32'h0000_0100;
  localparam logic [31:0] A1 = 32'h0000_0180;
  localparam logic [31:0] A3 = 32'h0000_0300;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- DUT signals ----------------
  logic [3:0]   req = '0, wen = '0, lock = '0;
  logic [31:0]  a2 = 32'h200;
  logic [127:0] addr_bus, wdata_bus;
  logic [31:0]  wd [4];
  logic [31:0]  rdata, ramaddr, ramstore;
  logic [31:0]  ramload = '0;
  logic [3:0]   rwait;
  logic         grant_valid, ramREN, ramWEN;
  logic [1:0]   grant_id;
  ramstate_t    rs = FREE;
  arb_state_t   dbg_state;

  assign wd[0] = 32'hD000_0000;
  assign wd[1] = 32'hD111_1111;
  assign wd[2] = 32'hD222_2222;
  assign wd[3] = 32'hD333_3333;
  assign addr_bus  = {A3, a2, A1, A0};
  assign wdata_bus = {wd[3], wd[2], wd[1], wd[0]};

  ram_arbiter #(.NREQ(4), .DMASK(4'b1100), .STARVE_MAX(2)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .req         (req),
    .wen         (wen),
    .lock        (lock),
    .addr        (addr_bus),
    .wdata       (wdata_bus),
    .rdata       (rdata),
    .rwait       (rwait),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .ramREN      (ramREN),
    .ramWEN      (ramWEN),
    .ramaddr     (ramaddr),
    .ramstore    (ramstore),
    .ramload     (ramload),
    .ramstate    (rs),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_miss = 0;
  logic [1:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Check the port outputs against one expected set.
  task automatic chk_all(input string tag, input logic [3:0] e_rwait, input logic e_ren,
                         input logic e_wen, input logic [31:0] e_addr, input logic e_gv,
                         input logic [1:0] e_gid);
    logic [31:0] e_store;
    n_vec++;
    e_store = e_gv ? wd[e_gid] : 32'h0;
    chk({tag, "_rwait"}, 32'(rwait), 32'(e_rwait));
    chk({tag, "_ren"}, 32'(ramREN), 32'(e_ren));
    chk({tag, "_wen"}, 32'(ramWEN), 32'(e_wen));
    chk({tag, "_addr"}, ramaddr, e_addr);
    chk({tag, "_store"}, ramstore, e_store);
    chk({tag, "_gv"}, 32'(grant_valid), 32'(e_gv));
    if (e_gv) chk({tag, "_gid"}, 32'(grant_id), 32'(e_gid));
    if (e_rwait != 4'b1111) chk({tag, "_rdata"}, rdata, ramload);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  req, wen, lock;
    ramstate_t   rs;
    logic [31:0] a2;
    logic [3:0]  e_rwait;
    logic        e_ren, e_wen;
    logic [31:0] e_addr;
    logic        e_gv;
    logic [1:0]  e_gid;
  } vec_t;

  vec_t vecs [$];

  task automatic reset_pulse();
    @(negedge CLK);
    nRST = 1'b0;
    req = '0; wen = '0; lock = '0; rs = FREE; a2 = 32'h200;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  // Watchdog: the bench is fixed-length, this only guards against a stall.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // all four requesting, single words: 0,1,2,3,0 with an IDLE bubble
    vecs.push_back('{4'b1111, 4'b0000, 4'b0000, FREE,   32'h200, 4'b1111, 1'b0, 1'b0, 32'h0,   1'b0, 2'd0});
    vecs.push_back('{4'b1111, 4'b0000, 4'b0000, ACCESS, 32'h200, 4'b1110, 1'b1, 1'b0, A0,      1'b1, 2'd0});
    vecs.push_back('{4'b1111, 4'b0000, 4'b0000, FREE,   32'h200, 4'b1111, 1'b0, 1'b0, 32'h0,   1'b0, 2'd0});
    vecs.push_back('{4'b1111, 4'b0000, 4'b0000, ACCESS, 32'h200, 4'b1101, 1'b1, 1'b0, A1,      1'b1, 2'd1});
    vecs.push_back('{4'b1111, 4'b0000, 4'b0000, FREE,   32'h200, 4'b1111, 1'b0, 1'b0, 32'h0,   1'b0, 2'd0});
    vecs.push_back('{4'b1111, 4'b0000, 4'b0000, ACCESS, 32'h200, 4'b1011, 1'b1, 1'b0, 32'h200, 1'b1, 2'd2});
    vecs.push_back('{4'b1111, 4'b0000, 4'b0000, FREE,   32'h200, 4'b1111, 1'b0, 1'b0, 32'h0,   1'b0, 2'd0});
    vecs.push_back('{4'b1111, 4'b0000, 4'b0000, ACCESS, 32'h200, 4'b0111, 1'b1, 1'b0, A3,      1'b1, 2'd3});
    vecs.push_back('{4'b1111, 4'b0000, 4'b0000, FREE,   32'h200, 4'b1111, 1'b0, 1'b0, 32'h0,   1'b0, 2'd0});
    vecs.push_back('{4'b1111, 4'b0000, 4'b0000, ACCESS, 32'h200, 4'b1110, 1'b1, 1'b0, A0,      1'b1, 2'd0});
    // single read by requester 0, RAM answers after two BUSY cycles
    vecs.push_back('{4'b0001, 4'b0000, 4'b0000, FREE,   32'h200, 4'b1111, 1'b0, 1'b0, 32'h0,   1'b0, 2'd0});
    vecs.push_back('{4'b0001, 4'b0000, 4'b0000, BUSY,   32'h200, 4'b1111, 1'b1, 1'b0, A0,      1'b1, 2'd0});
    vecs.push_back('{4'b0001, 4'b0000, 4'b0000, BUSY,   32'h200, 4'b1111, 1'b1, 1'b0, A0,      1'b1, 2'd0});
    vecs.push_back('{4'b0001, 4'b0000, 4'b0000, ACCESS, 32'h200, 4'b1110, 1'b1, 1'b0, A0,      1'b1, 2'd0});
    vecs.push_back('{4'b0000, 4'b0000, 4'b0000, FREE,   32'h200, 4'b1111, 1'b0, 1'b0, 32'h0,   1'b0, 2'd0});
    // locked write by requester 2 (0x200, 0x204) with req[0] pending, ERROR retried
    vecs.push_back('{4'b0101, 4'b0100, 4'b0100, FREE,   32'h200, 4'b1111, 1'b0, 1'b0, 32'h0,   1'b0, 2'd0});
    vecs.push_back('{4'b0101, 4'b0100, 4'b0100, ERROR,  32'h200, 4'b1111, 1'b0, 1'b1, 32'h200, 1'b1, 2'd2});
    vecs.push_back('{4'b0101, 4'b0100, 4'b0100, ACCESS, 32'h200, 4'b1011, 1'b0, 1'b1, 32'h200, 1'b1, 2'd2});
    vecs.push_back('{4'b0101, 4'b0100, 4'b0100, BUSY,   32'h204, 4'b1111, 1'b0, 1'b1, 32'h204, 1'b1, 2'd2});
    vecs.push_back('{4'b0101, 4'b0100, 4'b0100, ACCESS, 32'h204, 4'b1011, 1'b0, 1'b1, 32'h204, 1'b1, 2'd2});
    vecs.push_back('{4'b0001, 4'b0000, 4'b0000, FREE,   32'h200, 4'b1111, 1'b0, 1'b0, 32'h0,   1'b0, 2'd0});
    vecs.push_back('{4'b0001, 4'b0000, 4'b0000, ACCESS, 32'h200, 4'b1110, 1'b1, 1'b0, A0,      1'b1, 2'd0});
    // abort: requester 1 drops req in WORD1 while RAM is BUSY
    vecs.push_back('{4'b0010, 4'b0000, 4'b0000, FREE,   32'h200, 4'b1111, 1'b0, 1'b0, 32'h0,   1'b0, 2'd0});
    vecs.push_back('{4'b0010, 4'b0000, 4'b0000, BUSY,   32'h200, 4'b1111, 1'b1, 1'b0, A1,      1'b1, 2'd1});
    vecs.push_back('{4'b0000, 4'b0000, 4'b0000, BUSY,   32'h200, 4'b1111, 1'b0, 1'b0, A1,      1'b1, 2'd1});
    vecs.push_back('{4'b0000, 4'b0000, 4'b0000, ACCESS, 32'h200, 4'b1111, 1'b0, 1'b0, 32'h0,   1'b0, 2'd0});

    // reset state, checked while nRST is low
    #12;
    chk_all("reset", 4'b1111, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // table
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      req = vecs[i].req; wen = vecs[i].wen; lock = vecs[i].lock;
      rs = vecs[i].rs; a2 = vecs[i].a2;
      ramload = 32'hA5A5_0000 + 32'(i);
      #1;
      chk_all($sformatf("v%0d", i), vecs[i].e_rwait, vecs[i].e_ren, vecs[i].e_wen,
              vecs[i].e_addr, vecs[i].e_gv, vecs[i].e_gid);
    end

    // reset in the middle of a locked transfer (WORD2)
    @(negedge CLK);
    req = 4'b0100; lock = 4'b0100; wen = 4'b0000; rs = FREE; a2 = 32'h200;
    @(negedge CLK);
    rs = ACCESS; #1;
    chk_all("rst_w1", 4'b1011, 1'b1, 1'b0, 32'h200, 1'b1, 2'd2);
    @(negedge CLK);
    rs = BUSY; a2 = 32'h204; #1;
    chk_all("rst_w2", 4'b1111, 1'b1, 1'b0, 32'h204, 1'b1, 2'd2);
    #1 nRST = 1'b0;
    #1;
    chk_all("rst_async", 4'b1111, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0);
    @(negedge CLK);
    nRST = 1'b1; req = 4'b1111; lock = 4'b0000; rs = FREE; a2 = 32'h200;
    @(negedge CLK);
    rs = ACCESS; #1;
    chk_all("rst_after", 4'b1110, 1'b1, 1'b0, A0, 1'b1, 2'd0);

`ifdef MEMARB_DPRIO_EN
    // data priority with STARVE_MAX=2, req=1101 held: 2,3,0,2
    reset_pulse();
    exp_q = '{2'd2, 2'd3, 2'd0, 2'd2};
    req = 4'b1101;
    for (int g = 0; g < 4; g++) begin
      logic [1:0] e;
      @(negedge CLK);
      rs = FREE;
      @(negedge CLK);
      rs = ACCESS; #1;
      e = exp_q.pop_front();
      n_vec++;
      chk($sformatf("dprio_g%0d_gid", g), 32'(grant_id), 32'(e));
      chk($sformatf("dprio_g%0d_gv", g), 32'(grant_valid), 32'h1);
    end
`endif

    @(negedge CLK);
    req = '0; rs = FREE;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Round-robin arbiter that shares the single RAM port among NREQ cache-side requesters (icache0, icache1, dcache0, dcache1 in the dual-core build). It sits between the cache/coherence front end and the RAM model and owns the ram* signal group. It grants one requester at a time and holds the grant across a two-word block transfer (lock). It drives active-high per-requester wait signals in the same style as iwait/dwait.

## Interface
- NREQ, 4, number of requesters; index 0 has the highest initial priority.
- DMASK, 4'b1100, bit i set means requester i is a data requester; used only with the priority feature.
- STARVE_MAX, 8, consecutive data grants allowed before an instruction requester must win; priority feature only.
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- req  in  NREQ  access request, held until the final wait drops.
- wen  in  NREQ  1 = write, 0 = read.
- lock  in  NREQ  1 = two-word block; keep the grant for a second word.
- addr  in  NREQ x 32  word address, per requester.
- wdata  in  NREQ x 32  store data, per requester.
- rdata  out  32  ramload broadcast to all requesters.
- rwait  out  NREQ  1 = stall; 0 for exactly one cycle per completed word.
- grant_valid  out  1  a transfer is in progress.
- grant_id  out  clog2(NREQ)  current owner.
- ramREN, ramWEN  out  1 each  RAM strobes.
- ramaddr, ramstore  out  32 each  RAM address and data.
- ramload  in  32  RAM read data.
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR.

## Operation
- States: IDLE, WORD1, WORD2.
- **IDLE**
  - If any req is high, pick a winner by rotating search starting at (last_owner+1) mod NREQ.
  - Register the winner as owner and last_owner; go to WORD1.
  - No RAM strobes are driven in IDLE.
- **WORD1 / WORD2**
  - ramaddr = addr[owner] and ramstore = wdata[owner].
  - ramWEN = wen[owner] and ramREN = !wen[owner].
- **On ramstate==ACCESS**
  - rwait[owner] = 0 that cycle.
  - WORD1 goes to WORD2 if lock[owner] is set, otherwise to IDLE.
  - WORD2 goes to IDLE.
- The requester updates its own addr/wdata for the second word after the first wait drop. The arbiter never increments addresses.
- **ERROR or BUSY:** strobes stay high and the state holds (the access retries).
- **Abort:** if req[owner] drops in WORD1/WORD2 before ACCESS, strobes go low that cycle and the next state is IDLE. last_owner keeps the aborted id.
- **New requests:** requests arriving mid-transfer are not considered until the return to IDLE. There is no preemption inside a lock.
- **Non-owners:** rwait stays 1 for every non-owner at all times.
- **Reset values:**
  - owner = 0 and last_owner = NREQ-1.
  - State = IDLE.
  - rwait = all ones, ramREN = ramWEN = 0, ramaddr = ramstore = 0.
  - grant_valid = 0, grant_id = 0.
- **Reset mid-transfer:** the arbiter drops to the reset values immediately (asynchronously). The requester must reissue.

## Timing
- Grant latency: req high in cycle t while IDLE gives strobes in cycle t+1.
- Minimum occupancy is 2 cycles per single-word grant (IDLE + WORD1) plus RAM latency.
- A back-to-back grant to a different requester costs one IDLE bubble.
- grant_valid and grant_id are registered; they are valid in WORD1/WORD2.
- rdata is combinational from ramload. It is valid only in the cycle rwait[owner]=0.

## Configuration
- **MEMARB_DPRIO_EN undefined:** pure round-robin as above.
- **MEMARB_DPRIO_EN defined:**
  - In IDLE, requesters in DMASK win over non-DMASK requesters. Rotation applies within each class.
  - A saturating counter starve_cnt increments on each data grant made while some instruction req is pending. It clears on any instruction grant.
  - When starve_cnt == STARVE_MAX, instruction requesters win the next arbitration.
  - starve_cnt resets to 0.

## Structure
- **cpu_types_pkg:** ramstate_t already lives there. Add arb_state_t {IDLE, WORD1, WORD2} to cpu_types_pkg as well.
- **rr_pick (sub-module, combinational):** inputs request vector and last_owner; outputs one-hot winner and index. It is instantiated twice when MEMARB_DPRIO_EN is defined (data class, instruction class) and once otherwise.
- Counters and the state register stay in ram_arbiter.

## Test plan
- **Single read:** req=4'b0001, wen=0, addr[0]=0x100, RAM at ACCESS after 2 cycles -> ramREN=1, ramaddr=0x100, rwait[0]=0 for 1 cycle, rdata=ramload, then back to IDLE.
- **All four requesting continuously, single words:** grant order 0,1,2,3,0 with one IDLE cycle between grants.
- **Lock write by requester 2 (0x200, then 0x204) while req[0] is high:** two consecutive ACCESS pulses both go to requester 2; requester 0 is granted only afterwards.
- **Abort:** req[1] drops in WORD1 with ramstate=BUSY -> ramREN=ramWEN=0 the same cycle, IDLE next cycle, rwait[1] never 0.
- **Reset mid-WORD2:** nRST asserted -> rwait=4'b1111, strobes 0 without waiting for a clock; after release, requester 0 wins first.
- **With MEMARB_DPRIO_EN, STARVE_MAX=2, req=4'b1101 held:** grants go 2,3 then 0, then data resumes.
